ysyx_2022040010_mmio_resp: RTL and testbench
============================================

# ysyx_2022040010_mmio_resp

Uncached-side responder for the core's data port: services every access the address classifier routes as uncached and returns exactly one response per accepted request. Implements the serial TX register (8-entry byte FIFO toward the UART pins model) and a free-running microsecond RTC. Any other uncached address returns an error response. Sits between the LSU uncached request path and the simulated device ports.

## Interface
- UART_ADDR, 64'ha000_03f8, serial data register address (exact match)
- RTC_ADDR, 64'ha000_0048, RTC 64-bit register address (exact match)
- FIFO_DEPTH, 8, TX FIFO entries; power of two, ≥2
- CLK_PER_US, 4, clock cycles per RTC tick; ≥1
- clk  in  1  core clock; reset is asynchronous and active-low
- rst_n  in  1  asynchronous active-low reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted when valid&ready
- req_addr_i  in  64  physical address
- req_wen_i  in  1  1 = write, 0 = read
- req_wdata_i  in  64  write data
- req_wmask_i  in  8  byte write strobes
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response consumed when valid&ready
- rsp_rdata_o  out  64  read data (0 for writes and errors)
- rsp_err_o  out  1  unmapped address
- tx_valid_o  out  1  FIFO head valid
- tx_ready_i  in  1  sink takes head when valid&ready
- tx_data_o  out  8  FIFO head byte

## Operation
- FSM states IDLE, PUSH_WAIT, RESP. req_ready_o = (state==IDLE).
- IDLE, handshake: latch addr/wen/wdata/wmask; decode:
  - UART write, wmask[0]=1: FIFO not full → push wdata[7:0], go RESP; full → PUSH_WAIT.
  - UART write, wmask[0]=0: no push, RESP.
  - UART read: rdata = {63'b0, fifo_full}, RESP.
  - RTC read: rdata = mtime (value in acceptance cycle), RESP.
  - RTC write: each byte i with wmask[i] replaces mtime byte i; prescaler cleared; RESP.
  - else: err=1, rdata=0, RESP.
- PUSH_WAIT: push latched byte in first cycle FIFO not full (including cycle where pop frees a slot); then RESP.
- RESP: rsp_valid_o=1, rdata/err held stable; on rsp_ready_i → IDLE.
- FIFO: tx_valid_o = !empty, tx_data_o = head. Simultaneous push+pop: count unchanged, both take effect. Pointers wrap modulo FIFO_DEPTH.
- RTC: prescaler counts 0..CLK_PER_US-1; on terminal count mtime+=1 (64-bit, wraps to 0). RTC write in same cycle as tick: write wins, tick lost.

## Timing
- Reset (async assert, sync-clean deassert): state IDLE, req_ready_o=1, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, FIFO empty, tx_valid_o=0, tx_data_o=0, mtime=0, prescaler=0.
- Request accepted at edge N → rsp_valid_o high after edge N+1 (1-cycle latency), except full-FIFO UART write: response 1 cycle after the push.
- No new request accepted until response handshake completes; back-to-back throughput 1 req / 2 cycles with rsp_ready_i=1.
- Pushed byte visible on tx_valid_o the cycle after the push edge.
- Reset mid-transaction drops in-flight request, pending response and FIFO contents.

## Structure
- defines.v: `UART_ADDR, `RTC_ADDR defaults, FSM state encodings, alongside `CONFIG_MBASE/`CONFIG_MSIZE.
- Sub-module ysyx_2022040010_sync_fifo (parameterised width/depth, push/pop/full/empty, same clk/rst_n).

## Test plan
- Reset, then read RTC_ADDR after 40 idle cycles (CLK_PER_US=4) → rdata = 10 ±1 tick per alignment, err=0, valid 1 cycle after accept.
- Write 0x41,0x42,0x43 to UART_ADDR with tx_ready_i=1 → tx_data_o emits 0x41,0x42,0x43 in order; each write gets rdata=0, err=0.
- tx_ready_i=0, 9 UART writes → 8 respond at latency 1, 9th stalls in PUSH_WAIT; UART read blocked; raise tx_ready_i → 9th responds next cycle, sink sees 9 bytes in order.
- Write RTC_ADDR wdata=0xFFFF_FFFF_FFFF_FFFF, wmask=0xFF, wait 4 cycles, read → 0x0 (wrap); wmask=0x01 wdata=0x5A onto 0 → low byte 0x5A only.
- Read 0xa000_0100 → err=1, rdata=0; hold rsp_ready_i=0 for 5 cycles → rsp_valid_o/err stable, req_ready_o=0.
- Assert rst_n=0 during RESP with 3 bytes queued → outputs at reset values immediately; tx_valid_o=0 after release.

Source files
------------

// File: rtl/ysyx_2022040010_mmio_resp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_2022040010_mmio_resp_pkg
// Purpose  : Shared address map, FSM encodings and byte-merge helper for the
//            uncached MMIO responder.
// Revision : 1.0 - initial release
// ============================================================================
package ysyx_2022040010_mmio_resp_pkg;

  localparam logic [63:0] c_uart_addr = 64'ha000_03f8;
  localparam logic [63:0] c_rtc_addr  = 64'ha000_0048;

  localparam logic [1:0] c_st_idle      = 2'd0;
  localparam logic [1:0] c_st_push_wait = 2'd1;
  localparam logic [1:0] c_st_resp      = 2'd2;

  typedef enum logic [1:0] {
    DEV_UART = 2'd0,
    DEV_RTC  = 2'd1,
    DEV_NONE = 2'd2
  } dev_e;

  // Replace the bytes of old_v selected by mask with those of new_v.
  function automatic logic [63:0] merge_bytes(input logic [63:0] old_v,
                                              input logic [63:0] new_v,
                                              input logic [7:0]  mask);
    logic [63:0] res;
    res = old_v;
    for (int i = 0; i < 8; i++) begin
      if (mask[i]) res[i*8 +: 8] = new_v[i*8 +: 8];
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_2022040010_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_2022040010_sync_fifo
// Purpose  : Single-clock FIFO; a push is accepted while full if a pop frees
//            a slot in the same cycle. Head reads as zero when empty.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_2022040010_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty
);

  localparam int c_aw = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [c_aw:0]   c_depth   = DEPTH[c_aw:0];
  localparam logic [c_aw:0]   c_cnt_one = 1;
  localparam logic [c_aw-1:0] c_ptr_one = 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_aw-1:0]  r_wptr;
  logic [c_aw-1:0]  r_rptr;
  logic [c_aw:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == c_depth);
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_head    = o_empty ? '0 : r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_push_data;
  end

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + c_ptr_one;
      if (w_do_pop)  r_rptr <= r_rptr + c_ptr_one;
      if (w_do_push && !w_do_pop)      r_count <= r_count + c_cnt_one;
      else if (w_do_pop && !w_do_push) r_count <= r_count - c_cnt_one;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ysyx_2022040010_mmio_resp.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_2022040010_mmio_resp
// Purpose  : Uncached-side responder: UART TX FIFO register, microsecond RTC,
//            error response for every other address; one response per request.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_2022040010_mmio_resp
  import ysyx_2022040010_mmio_resp_pkg::*;
#(
  parameter logic [63:0] UART_ADDR  = c_uart_addr,
  parameter logic [63:0] RTC_ADDR   = c_rtc_addr,
  parameter int          FIFO_DEPTH = 8,
  parameter int          CLK_PER_US = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [63:0] req_addr_i,
  input  logic        req_wen_i,
  input  logic [63:0] req_wdata_i,
  input  logic [7:0]  req_wmask_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [63:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic [7:0]  tx_data_o
);

  localparam int c_pw = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
  localparam logic [c_pw-1:0] c_presc_last = c_pw'(CLK_PER_US - 1);
  localparam logic [c_pw-1:0] c_presc_one  = 1;

  logic [1:0]      r_state;
  logic [63:0]     r_rdata;
  logic            r_err;
  logic [7:0]      r_wbyte;
  logic [63:0]     r_mtime;
  logic [c_pw-1:0] r_presc;

  dev_e            w_dev;
  logic            w_acc;
  logic            w_full;
  logic            w_empty;
  logic            w_push_idle;
  logic            w_push_wait;
  logic            w_push;
  logic [7:0]      w_push_data;
  logic            w_rtc_wr;

  always_comb begin
    w_dev = DEV_NONE;
    if (req_addr_i == UART_ADDR)     w_dev = DEV_UART;
    else if (req_addr_i == RTC_ADDR) w_dev = DEV_RTC;
  end

  assign req_ready_o = (r_state == c_st_idle);
  assign rsp_valid_o = (r_state == c_st_resp);
  assign rsp_rdata_o = r_rdata;
  assign rsp_err_o   = r_err;
  assign tx_valid_o  = !w_empty;

  assign w_acc       = req_valid_i && req_ready_o;
  assign w_push_idle = w_acc && (w_dev == DEV_UART) && req_wen_i && req_wmask_i[0] && !w_full;
  // A pop in the same cycle frees the slot the stalled byte needs.
  assign w_push_wait = (r_state == c_st_push_wait) && (!w_full || tx_ready_i);
  assign w_push      = w_push_idle || w_push_wait;
  assign w_push_data = (r_state == c_st_push_wait) ? r_wbyte : req_wdata_i[7:0];
  assign w_rtc_wr    = w_acc && (w_dev == DEV_RTC) && req_wen_i;

  ysyx_2022040010_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (tx_ready_i),
    .o_head      (tx_data_o),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_st_idle;
      r_rdata <= '0;
      r_err   <= 1'b0;
      r_wbyte <= '0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (w_acc) begin
            r_rdata <= '0;
            r_err   <= 1'b0;
            r_wbyte <= req_wdata_i[7:0];
            r_state <= c_st_resp;
            case (w_dev)
              DEV_UART: begin
                if (req_wen_i) begin
                  if (req_wmask_i[0] && w_full) r_state <= c_st_push_wait;
                end else begin
                  r_rdata <= {63'b0, w_full};
                end
              end
              DEV_RTC: begin
                if (!req_wen_i) r_rdata <= r_mtime;
              end
              default: r_err <= 1'b1;
            endcase
          end
        end
        c_st_push_wait: begin
          if (w_push_wait) r_state <= c_st_resp;
        end
        c_st_resp: begin
          if (rsp_ready_i) r_state <= c_st_idle;
        end
        default: r_state <= c_st_idle;
      endcase
    end
  end

  // A register write overrides a coincident tick and restarts the prescaler.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mtime <= '0;
      r_presc <= '0;
    end else if (w_rtc_wr) begin
      r_mtime <= merge_bytes(r_mtime, req_wdata_i, req_wmask_i);
      r_presc <= '0;
    end else if (r_presc == c_presc_last) begin
      r_presc <= '0;
      r_mtime <= r_mtime + 64'd1;
    end else begin
      r_presc <= r_presc + c_presc_one;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_2022040010_mmio_resp.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_2022040010_mmio_resp
// Purpose  : Scoreboard bench for the uncached MMIO responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_2022040010_mmio_resp;

  localparam logic [63:0] UART  = 64'ha000_03f8;
  localparam logic [63:0] RTC   = 64'ha000_0048;
  localparam int          DEPTH = 8;
  localparam int          CPU   = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [63:0] req_addr_i = '0;
  logic        req_wen_i = 1'b0;
  logic [63:0] req_wdata_i = '0;
  logic [7:0]  req_wmask_i = '0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b1;
  logic [63:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic        tx_valid_o;
  logic        tx_ready_i = 1'b1;
  logic [7:0]  tx_data_o;

  ysyx_2022040010_mmio_resp #(
    .UART_ADDR  (UART),
    .RTC_ADDR   (RTC),
    .FIFO_DEPTH (DEPTH),
    .CLK_PER_US (CPU)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_addr_i  (req_addr_i),
    .req_wen_i   (req_wen_i),
    .req_wdata_i (req_wdata_i),
    .req_wmask_i (req_wmask_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_rdata_o (rsp_rdata_o),
    .rsp_err_o   (rsp_err_o),
    .tx_valid_o  (tx_valid_o),
    .tx_ready_i  (tx_ready_i),
    .tx_data_o   (tx_data_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  txq[$];
  int          errors = 0;
  int          checks = 0;
  int unsigned cyc;
  logic [63:0] rtc_base = '0;
  int unsigned rtc_edge = 0;
  int          rr_mode = 1;  // 0 hold low, 1 hold high, 2 random
  int          tr_mode = 1;

  // Edges since the last reset release; edge 1 is the first one.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // mtime as seen just before edge k: one tick per CPU edges since the last write/reset.
  function automatic logic [63:0] rtc_at(input int unsigned k);
    return rtc_base + 64'((k - rtc_edge - 1) / CPU);
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] o, input logic [63:0] n, input logic [7:0] m);
    logic [63:0] r;
    r = o;
    for (int b = 0; b < 8; b++) if (m[b]) r[b*8 +: 8] = n[b*8 +: 8];
    return r;
  endfunction

  initial forever begin
    @(posedge clk);
    #2;
    rsp_ready_i = (rr_mode == 2) ? 1'($urandom_range(0, 1)) : (rr_mode == 1);
    tx_ready_i  = (tr_mode == 2) ? 1'($urandom_range(0, 1)) : (tr_mode == 1);
  end

  initial begin : monitor
    exp_t       e;
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (rst_n && rsp_valid_o && rsp_ready_i) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL rsp_unexpected: got rdata %h err %b expected no response", rsp_rdata_o, rsp_err_o);
        end else begin
          e = sb.pop_front();
          chk("rsp_rdata", rsp_rdata_o, e.rdata);
          chk("rsp_err", 64'(rsp_err_o), 64'(e.err));
        end
      end
      if (rst_n && tx_valid_o && tx_ready_i) begin
        if (txq.size() == 0) begin
          checks++; errors++;
          $display("FAIL tx_unexpected: got byte %h expected none", tx_data_o);
        end else begin
          b = txq.pop_front();
          chk("tx_data", 64'(tx_data_o), 64'(b));
        end
      end
    end
  end

  task automatic send(input logic [63:0] addr, input logic wen, input logic [63:0] wdata,
                      input logic [7:0] wmask, input bit chk_lat);
    exp_t        e;
    int unsigned k;
    int          n;
    @(posedge clk);
    #1;
    req_valid_i = 1'b1;
    req_addr_i  = addr;
    req_wen_i   = wen;
    req_wdata_i = wdata;
    req_wmask_i = wmask;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready_o && n < 200);
    if (!req_ready_o) begin
      checks++; errors++;
      $display("FAIL req_timeout: got req_ready_o=0 for %0d cycles expected acceptance", n);
      req_valid_i = 1'b0;
      return;
    end
    k = cyc + 1;
    e.rdata = '0;
    e.err   = 1'b0;
    if (addr == UART) begin
      if (wen) begin
        if (wmask[0]) txq.push_back(wdata[7:0]);
      end else begin
        e.rdata = {63'b0, (txq.size() >= DEPTH)};
      end
    end else if (addr == RTC) begin
      if (wen) begin
        rtc_base = merge(rtc_at(k), wdata, wmask);
        rtc_edge = k;
      end else begin
        e.rdata = rtc_at(k);
      end
    end else begin
      e.err = 1'b1;
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
    if (chk_lat) begin
      @(negedge clk);
      chk("rsp_latency", 64'(rsp_valid_o), 64'd1);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || txq.size() != 0) && n < 500) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0 || txq.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d responses and %0d bytes outstanding expected 0", sb.size(), txq.size());
    end
  endtask

  task automatic random_phase(input int count, input bit no_uart_read);
    int          sel;
    logic [63:0] addr;
    logic        wen;
    for (int i = 0; i < count; i++) begin
      sel = $urandom_range(0, 3);
      if (sel <= 1)     addr = UART;
      else if (sel == 2) addr = RTC;
      else begin
        addr = {32'h0, $urandom};
        if (addr == UART || addr == RTC) addr = addr ^ 64'h1;
      end
      wen = 1'($urandom_range(0, 1));
      if (no_uart_read && addr == UART) wen = 1'b1;
      send(addr, wen, {$urandom, $urandom}, 8'($urandom), 1'b0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected completion within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #3;
    chk("rst_req_ready", 64'(req_ready_o), 64'd1);
    chk("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
    chk("rst_rdata",     rsp_rdata_o,      64'd0);
    chk("rst_err",       64'(rsp_err_o),   64'd0);
    chk("rst_tx_valid",  64'(tx_valid_o),  64'd0);
    chk("rst_tx_data",   64'(tx_data_o),   64'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;

    // RTC after idle time
    repeat (40) @(posedge clk);
    send(RTC, 1'b0, '0, '0, 1'b1);
    checks++;
    if (rsp_rdata_o < 64'd9 || rsp_rdata_o > 64'd11) begin
      errors++;
      $display("FAIL rtc_idle_range: got %0d expected 9..11", rsp_rdata_o);
    end

    // ordered UART output
    send(UART, 1'b1, 64'h41, 8'h01, 1'b1);
    send(UART, 1'b1, 64'h42, 8'h01, 1'b1);
    send(UART, 1'b1, 64'h43, 8'h01, 1'b1);
    send(UART, 1'b1, 64'h44, 8'h00, 1'b1);
    drain();

    // FIFO full stall
    tr_mode = 0;
    @(posedge clk);
    for (int i = 0; i < DEPTH; i++) send(UART, 1'b1, 64'h60 + 64'(i), 8'hff, 1'b1);
    send(UART, 1'b0, '0, '0, 1'b1);
    send(UART, 1'b1, 64'h68, 8'h01, 1'b0);
    repeat (3) begin
      @(negedge clk);
      chk("stall_rsp_valid", 64'(rsp_valid_o), 64'd0);
      chk("stall_req_ready", 64'(req_ready_o), 64'd0);
    end
    @(posedge clk);
    #1 tr_mode = 1;
    @(negedge clk);
    chk("stall_hold", 64'(rsp_valid_o), 64'd0);
    @(negedge clk);
    chk("stall_release", 64'(rsp_valid_o), 64'd1);
    drain();
    send(UART, 1'b0, '0, '0, 1'b1);

    // RTC wrap and byte-masked write
    send(RTC, 1'b1, 64'hffff_ffff_ffff_ffff, 8'hff, 1'b1);
    repeat (4) @(posedge clk);
    send(RTC, 1'b0, '0, '0, 1'b1);
    chk("rtc_wrap", rsp_rdata_o, 64'd0);
    send(RTC, 1'b1, 64'h1234_5678_9abc_de5a, 8'h01, 1'b1);
    send(RTC, 1'b0, '0, '0, 1'b1);
    chk("rtc_mask", rsp_rdata_o, 64'h5a);

    // unmapped read with back-pressure
    rr_mode = 0;
    send(64'ha000_0100, 1'b0, '0, '0, 1'b1);
    repeat (5) begin
      @(negedge clk);
      chk("err_hold_valid", 64'(rsp_valid_o), 64'd1);
      chk("err_hold_err",   64'(rsp_err_o),   64'd1);
      chk("err_hold_rdata", rsp_rdata_o,      64'd0);
      chk("err_hold_ready", 64'(req_ready_o), 64'd0);
    end
    rr_mode = 1;
    drain();

    // reset during a pending response with bytes queued
    tr_mode = 0;
    @(posedge clk);
    send(UART, 1'b1, 64'h71, 8'h01, 1'b1);
    send(UART, 1'b1, 64'h72, 8'h01, 1'b1);
    send(UART, 1'b1, 64'h73, 8'h01, 1'b1);
    rr_mode = 0;
    send(RTC, 1'b0, '0, '0, 1'b1);
    chk("pre_rst_tx_valid", 64'(tx_valid_o), 64'd1);
    #2 rst_n = 1'b0;
    sb.delete();
    txq.delete();
    rtc_base = '0;
    rtc_edge = 0;
    #1;
    chk("mid_rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
    chk("mid_rst_req_ready", 64'(req_ready_o), 64'd1);
    chk("mid_rst_rdata",     rsp_rdata_o,      64'd0);
    chk("mid_rst_tx_valid",  64'(tx_valid_o),  64'd0);
    chk("mid_rst_tx_data",   64'(tx_data_o),   64'd0);
    rr_mode = 1;
    tr_mode = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_tx_valid",  64'(tx_valid_o),  64'd0);
    chk("post_rst_rsp_valid", 64'(rsp_valid_o), 64'd0);

    // randomized traffic
    rr_mode = 2;
    random_phase(150, 1'b0);
    tr_mode = 2;
    random_phase(100, 1'b1);
    tr_mode = 1;
    rr_mode = 1;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
